// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: FSM states, blank
// patterns and the active-low hex segment table.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Index = hex nibble, value = {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);
    import seg7_pkg::*;

    always_comb begin
        seg_c = SEG_BLANK;
        seg_c = HEX_SEG[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver with per-slot blanking and
// frame-based rotation offset for the upstream register multiplexer.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEAD_CYCLES    = 500,
    parameter int unsigned FRAMES_PER_ROT = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rot_en,
    input  logic [3:0] char_in,
    output logic [1:0] digit_sel,
    output logic [3:0] rot_counter,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    import seg7_pkg::*;

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (FRAMES_PER_ROT > 1) ? $clog2(FRAMES_PER_ROT) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(FRAMES_PER_ROT - 1);

    scan_state_e      state, state_d;
    logic [CNT_W-1:0] slot_cnt, slot_cnt_d;
    logic [FRM_W-1:0] frame_cnt, frame_cnt_d;
    logic [3:0]       char_q, char_q_d;
    logic [1:0]       digit_sel_d;
    logic [3:0]       rot_counter_d;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;
    logic [6:0]       seg_dec_c;
    logic             slot_end;

    assign dp       = 1'b1;
    assign slot_end = (slot_cnt == SLOT_LAST);

    // Decode the value that char_q will hold after this edge so seg lights
    // together with the anode on the BLANK->SHOW edge.
    seg7_hex_decoder u_dec (
        .nibble (char_q_d),
        .seg_c  (seg_dec_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BLANK;
            slot_cnt    <= '0;
            frame_cnt   <= '0;
            char_q      <= '0;
            digit_sel   <= '0;
            rot_counter <= '0;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
        end else begin
            state       <= state_d;
            slot_cnt    <= slot_cnt_d;
            frame_cnt   <= frame_cnt_d;
            char_q      <= char_q_d;
            digit_sel   <= digit_sel_d;
            rot_counter <= rot_counter_d;
            an          <= an_d;
            seg         <= seg_d;
        end
    end

    always_comb begin
        state_d       = state;
        slot_cnt_d    = slot_end ? '0 : slot_cnt + CNT_W'(1);
        frame_cnt_d   = frame_cnt;
        char_q_d      = char_q;
        digit_sel_d   = digit_sel;
        rot_counter_d = rot_counter;
        an_d          = AN_OFF;
        seg_d         = SEG_BLANK;

        case (state)
            BLANK: begin
                if (slot_cnt == DEAD_LAST) begin
                    char_q_d = char_in;
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                if (slot_end) begin
                    state_d     = BLANK;
                    digit_sel_d = digit_sel + 2'd1;
                    // Rotation only moves between frames, never mid-frame
                    if (digit_sel == 2'd3) begin
                        if (frame_cnt == FRM_LAST) begin
                            frame_cnt_d = '0;
                            if (rot_en) begin
                                rot_counter_d = rot_counter + 4'd1;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt + FRM_W'(1);
                        end
                    end
                end
            end
            default: state_d = BLANK;
        endcase

        if (state_d == SHOW) begin
            an_d  = ~(4'b1000 >> digit_sel_d);
            seg_d = seg_dec_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a
// cycle-count based reference model.
module tb_seg7_scan_driver;

    localparam int unsigned SCAN_DIV       = 8;
    localparam int unsigned DEAD_CYCLES    = 2;
    localparam int unsigned FRAMES_PER_ROT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rot_en;
    logic [3:0] char_in;
    logic [1:0] digit_sel;
    logic [3:0] rot_counter;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks   = 0;
    int failures = 0;

    // Reference model state: edges since reset, current offset, latched char
    int         cyc;
    int         ref_rot;
    logic [3:0] ref_cap;

    logic [6:0] ref_seg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg7_scan_driver #(
        .SCAN_DIV       (SCAN_DIV),
        .DEAD_CYCLES    (DEAD_CYCLES),
        .FRAMES_PER_ROT (FRAMES_PER_ROT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rot_en      (rot_en),
        .char_in     (char_in),
        .digit_sel   (digit_sel),
        .rot_counter (rot_counter),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_digit();
        return (cyc / SCAN_DIV) % 4;
    endfunction

    task automatic model_reset();
        cyc     = 0;
        ref_rot = 0;
        ref_cap = 4'h0;
    endtask

    // Apply one rising edge to the model using the inputs present at that edge
    task automatic model_edge();
        int pos;
        int slot;
        pos  = cyc % SCAN_DIV;
        slot = cyc / SCAN_DIV;
        if (pos == DEAD_CYCLES - 1) ref_cap = char_in;
        if (pos == SCAN_DIV - 1 && slot % 4 == 3 &&
            ((slot / 4) + 1) % FRAMES_PER_ROT == 0 && rot_en)
            ref_rot = (ref_rot + 1) % 16;
        cyc++;
    endtask

    task automatic check_outputs();
        int   pos;
        logic show;
        logic [3:0] exp_an;
        pos    = cyc % SCAN_DIV;
        show   = (pos >= DEAD_CYCLES);
        exp_an = show ? ~(4'b1000 >> exp_digit()) : 4'b1111;
        check("an", an, exp_an);
        check("seg", seg, show ? ref_seg[ref_cap] : 7'h7F);
        check("digit_sel", digit_sel, exp_digit());
        check("rot_counter", rot_counter, ref_rot);
        check("dp", dp, 1'b1);
        check("an_onehot", ($countones(~an) <= 1), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_an"}, an, 4'b1111);
        check({tag, "_seg"}, seg, 7'h7F);
        check({tag, "_dp"}, dp, 1'b1);
        check({tag, "_digit"}, digit_sel, 2'd0);
        check({tag, "_rot"}, rot_counter, 4'd0);
    endtask

    task automatic step(input logic [3:0] c, input logic e);
        char_in = c;
        rot_en  = e;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Upstream-like source: char follows the requested digit plus offset
    function automatic logic [3:0] upstream_char();
        return 4'((exp_digit() + ref_rot) % 16);
    endfunction

    initial begin
        reset   = 1'b0;
        rot_en  = 1'b0;
        char_in = 4'h0;
        model_reset();
        #12;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // One full frame of the scan order with upstream-style chars
        repeat (4 * SCAN_DIV) step(upstream_char(), 1'b0);

        // Asynchronous reset in the middle of a SHOW phase
        while (cyc % SCAN_DIV != 4) step(upstream_char(), 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (10) @(posedge clk);
        #1;
        check_reset_values("held_rst");
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // 34 frames with rotation enabled: offset wraps 15 -> 0
        repeat (34 * 4 * SCAN_DIV) step(upstream_char(), 1'b1);
        check("rot_after_34_frames", rot_counter, 4'd1);

        // Frozen across rotation boundaries
        repeat (4 * 4 * SCAN_DIV) step(upstream_char(), 1'b0);
        // Single-cycle enable pulses away from the frame boundary
        for (int i = 0; i < 2 * 4 * SCAN_DIV; i++)
            step(upstream_char(), (cyc % (4 * SCAN_DIV)) == 5);
        check("rot_frozen", rot_counter, 4'd1);

        // Settling: only the value present at the capture edge is shown
        for (int i = 0; i < 8 * SCAN_DIV; i++)
            step(4'($urandom_range(0, 15)), 1'b0);

        // Decoder sweep over all 16 nibbles
        for (int v = 0; v < 16; v++)
            repeat (SCAN_DIV) step(4'(v), 1'b0);

        // Random chars and sparse random rotation enables
        for (int i = 0; i < 2000; i++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for the 4-digit common-anode seven-segment display on the Spartan-3 board.
- Each scan slot presents a digit index (digit_sel) and a rotation offset (rot_counter) to the upstream register multiplexer.
- It samples the returned 4-bit char, decodes it to hex segment patterns and enables one anode at a time.
- Inserts blanking dead time between digits to suppress ghosting.
- Advances the rotation offset at frame boundaries, which produces the scrolling effect.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz); legal range DEAD_CYCLES+2 .. 2^20.
DEAD_CYCLES, 500, blanking cycles at the start of each slot; legal range >= 2.
FRAMES_PER_ROT, 250, full 4-digit frames per rotation step (1 s per step with defaults); legal range >= 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
rot_en  in  1  1 = rotation offset advances; 0 = rotation offset frozen
char_in  in  4  hex nibble from upstream multiplexer for the current digit_sel/rot_counter
digit_sel  out  2  digit index currently requested (0 = leftmost)
rot_counter  out  4  rotation offset supplied to upstream
an  out  4  anode enables, active-low; an[3] = leftmost digit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low; held at 1 (off)

Behaviour:
- Reset (reset = 0, asynchronous, takes effect immediately, including mid-slot):
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - digit_sel = 0, rot_counter = 0.
  - Slot counter = 0, frame counter = 0, state = BLANK.
- After reset is released, operation starts on the first rising clk edge.
- Slot counter counts 0..SCAN_DIV-1, then wraps to 0. Each wrap ends the slot.
- FSM, two states:
  - BLANK (slot count 0..DEAD_CYCLES-1):
    - an = 4'b1111, seg = 7'b1111111.
    - digit_sel and rot_counter held stable.
    - At count DEAD_CYCLES-1, char_in is registered into char_q (upstream has DEAD_CYCLES-1 cycles to settle).
    - Next state SHOW.
  - SHOW (slot count DEAD_CYCLES..SCAN_DIV-1):
    - an[3-digit_sel] = 0, other anodes 1.
    - seg = decode(char_q), registered, so outputs change on the BLANK->SHOW edge.
    - At count SCAN_DIV-1: digit_sel increments mod 4 (3 -> 0), next state BLANK.
- Anode/segment output timing:
  - Never more than one anode low at a time.
  - Anode goes high on the same edge the slot ends.
  - Segment outputs go high (blank) on the same edge the slot ends.
- Frame boundary = end of slot with digit_sel = 3.
  - Frame counter increments at each frame boundary.
  - When the frame counter reaches FRAMES_PER_ROT-1, it wraps to 0. On that edge, if rot_en = 1, rot_counter increments mod 16 (15 -> 0).
  - rot_en is sampled only on that edge. Toggling it elsewhere has no effect, and the frame counter keeps running regardless of rot_en.
  - rot_counter never changes mid-frame, so one frame never mixes two offsets.
- Upstream wraps regSel + rot_counter mod 16; this block imposes no extra wrap rule.
- Hex decode (active-low gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- No X propagation: all state registers have reset values, and the decoder default is blank.

Decomposition:
- Package seg7_pkg:
  - FSM state encoding (BLANK, SHOW).
  - SEG_BLANK = 7'b1111111, AN_OFF = 4'b1111.
  - 16-entry hex-to-segment constant table.
- Sub-module seg7_hex_decoder: purely combinational, 4-bit in, 7-bit active-low out, using the package table.
- Prescaler, FSM and frame/rotation counters live in seg7_scan_driver.

Test Plan:
- Reset: hold reset = 0 for 10 cycles mid-SHOW -> an = 1111, seg = 1111111, dp = 1, digit_sel = 0, rot_counter = 0 within the same cycle, with no clock required.
- Scan order (SCAN_DIV = 8, DEAD_CYCLES = 2): char_in = digit_sel + rot_counter -> per slot:
  - 2 cycles with an = 1111,
  - then 6 cycles with an = 0111, 1011, 1101, 1110 in turn,
  - seg showing 0, 1, 2, 3 respectively.
- Settling: char_in changes only at cycle DEAD_CYCLES-1 of the slot -> new value is shown. A change at cycle DEAD_CYCLES (already in SHOW) is ignored until the next slot.
- Rotation (FRAMES_PER_ROT = 2, rot_en = 1): run 34 frames -> rot_counter steps every 2 frames and wraps 15 -> 0 after frame 32. It changes only on the digit-3 -> digit-0 edge.
- Freeze: rot_en = 0 across a rotation boundary -> rot_counter holds; frame counter continues. rot_en = 1 for a single cycle not on the boundary -> no step.
- Decoder sweep: char_in = 0..F -> seg matches each of the 16 table entries exactly; never more than one anode low at any sampled cycle.
